led_pattern_driver: RTL



---
 rtl/led_pattern_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/led_pattern_driver.sv
// Animated N-LED pattern driver: six stepped patterns with global PWM brightness.
// The pattern advances every STEP_DIV clocks. A mode change reloads the pattern and restarts the step timer.
module led_pattern_driver #(
   parameter int N_LED    = 16,
   parameter int STEP_DIV = 25_000_000,
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          mode,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [N_LED-1:0]    led_out,
   output logic                step
);

   localparam int                PRE_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   typedef enum logic [2:0] {
      M_OFF     = 3'b000,
      M_ON      = 3'b001,
      M_CHASE_L = 3'b010,
      M_CHASE_R = 3'b011,
      M_BLINK   = 3'b100,
      M_FILL    = 3'b101,
      M_RSV6    = 3'b110,
      M_RSV7    = 3'b111
   } mode_e;

   mode_e               mode_q, mode_d;
   logic [N_LED-1:0]    pattern_q, pattern_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic                step_d;
   logic [PWM_BITS-1:0] pwm_cnt, brightness_q, brightness_d;
   logic                pwm_on;
   logic                load;

   function automatic logic [N_LED-1:0] init_pat(input mode_e m);
      logic [N_LED-1:0] p;
      p = '0;
      case (m)
         M_ON, M_BLINK:     p = '1;
         M_CHASE_L, M_FILL: p = N_LED'(1);
         M_CHASE_R:         p = {1'b1, {(N_LED-1){1'b0}}};
         default:           p = '0;
      endcase
      return p;
   endfunction

   function automatic logic [N_LED-1:0] adv_pat(input mode_e m, input logic [N_LED-1:0] p);
      logic [N_LED-1:0] n;
      n = p;
      case (m)
         M_CHASE_L: n = {p[N_LED-2:0], p[N_LED-1]};
         M_CHASE_R: n = {p[0], p[N_LED-1:1]};
         M_BLINK:   n = ~p;
         // full bar empties, otherwise grow by one lit LED from bit0
         M_FILL:    n = (&p) ? '0 : {p[N_LED-2:0], 1'b1};
         default:   n = p;
      endcase
      return n;
   endfunction

   always_comb begin
      mode_d    = mode_q;
      pattern_d = pattern_q;
      pre_d     = pre_q + PRE_W'(1);
      step_d    = 1'b0;
      load      = (mode_e'(mode) != mode_q);
      if (load) begin
         // a load always beats a coincident tick
         mode_d    = mode_e'(mode);
         pre_d     = '0;
         pattern_d = init_pat(mode_e'(mode));
      end else if (pre_q == PRE_LAST) begin
         pre_d     = '0;
         step_d    = 1'b1;
         pattern_d = adv_pat(mode_q, pattern_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= M_OFF;
         pattern_q <= '0;
         pre_q     <= '0;
         step      <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         pattern_q <= pattern_d;
         pre_q     <= pre_d;
         step      <= step_d;
      end
   end

   // brightness only sampled at the period boundary so duty never glitches
   always_comb begin
      brightness_d = (pwm_cnt == PWM_MAX) ? brightness : brightness_q;
      pwm_on       = (brightness_q == PWM_MAX) || (pwm_cnt < brightness_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_cnt      <= '0;
         brightness_q <= '0;
      end else begin
         pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
         brightness_q <= brightness_d;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) led_out[i] <= 1'b0;
         else      led_out[i] <= pattern_q[i] & pwm_on;
      end
   end

endmodule
